// File: rtl/uart_pkg.sv
// Constants and the TX handshake state encoding shared by the UART blocks.
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned SB_TICKS   = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StWaitDone = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with a separate occupancy counter and registered read data.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam int unsigned            Depth     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]    FullCount = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    CntOne    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]  PtrOne    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  push, pop;

  // A pop in the same cycle frees a slot, so a write against a full FIFO still lands.
  assign pop  = i_rd & ~empty_q;
  assign push = i_wr & (~full_q | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      rdata_d  = mem_q[rd_ptr_q];
    end
    if (push && !pop)      count_d = count_q + CntOne;
    else if (pop && !push) count_d = count_q - CntOne;
    full_d  = (count_d == FullCount);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = rdata_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers bytes for uart_tx and releases them one at a time via the start/done handshake.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy
);

  import uart_pkg::*;

  tx_state_e state_q, state_d;
  logic      overflow_q, overflow_d;
  logic      fifo_rd, fifo_full, fifo_empty;

  // Read data is registered and only updates on a pop, so it doubles as the held tx byte.
  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_wr   (i_wr),
    .i_wdata(i_wdata),
    .i_rd   (fifo_rd),
    .o_rdata(o_tx_data),
    .o_full (fifo_full),
    .o_empty(fifo_empty),
    .o_count(o_count)
  );

  always_comb begin
    state_d = state_q;
    fifo_rd = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = StStart;
        end
      end
      StStart:    state_d = StWaitDone;
      StWaitDone: if (i_tx_done) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    overflow_d = overflow_q | (i_wr & fifo_full & ~fifo_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_full     = fifo_full;
  assign o_empty    = fifo_empty;
  assign o_overflow = overflow_q;
  assign o_tx_start = (state_q == StStart);
  assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue-based reference model plus an emulated uart_tx.
module tb_uart_tx_fifo;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_wr = 1'b0;
  logic [7:0] i_wdata = 8'h00;
  logic       i_tx_done = 1'b0;
  logic       o_full, o_empty, o_overflow, o_tx_start, o_busy;
  logic [4:0] o_count;
  logic [7:0] o_tx_data;

  uart_tx_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_wr      (i_wr),
    .i_wdata   (i_wdata),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_count   (o_count),
    .o_overflow(o_overflow),
    .o_tx_start(o_tx_start),
    .o_tx_data (o_tx_data),
    .i_tx_done (i_tx_done),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes waiting in the FIFO, plus the in-flight frame.
  logic [7:0] model_q[$];
  logic [7:0] sb_q[$];
  bit         m_busy = 0;
  bit         m_start = 0;
  bit         m_ovf = 0;
  logic [7:0] m_last = 8'h00;
  bit         armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // One clock: apply inputs, then advance the model by the rules for that edge.
  task automatic step(input bit wr, input logic [7:0] d, input bit done, input bit rst);
    bit pop, acc;
    i_wr      = wr;
    i_wdata   = d;
    i_tx_done = done;
    reset     = rst;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      sb_q.delete();
      m_busy  = 0;
      m_start = 0;
      m_ovf   = 0;
      m_last  = 8'h00;
    end else begin
      pop = !m_busy && (model_q.size() > 0);
      acc = wr && ((model_q.size() < Depth) || pop);
      if (wr && !acc) m_ovf = 1;
      if (pop) begin
        m_last  = model_q.pop_front();
        m_busy  = 1;
        m_start = 1;
      end else if (m_start) begin
        m_start = 0;
      end else if (m_busy && done) begin
        m_busy = 0;
      end
      if (acc) begin
        model_q.push_back(d);
        sb_q.push_back(d);
      end
    end
    armed = 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  // Emulated uart_tx: finishes each frame after a random number of cycles.
  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (model_q.size() == 0 && !m_busy) break;
      step(0, 8'h00, m_busy && !m_start && ($urandom_range(0, 3) == 0), 0);
    end
    idle(2);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("count", 32'(o_count), 32'(model_q.size()));
      chk("empty", 32'(o_empty), 32'(model_q.size() == 0));
      chk("full", 32'(o_full), 32'(model_q.size() == Depth));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("tx_start", 32'(o_tx_start), 32'(m_start));
      chk("tx_data_held", 32'(o_tx_data), 32'(m_last));
      if (o_tx_start === 1'b1) begin
        if (sb_q.size() == 0) chk("start_without_write", 32'(o_tx_start), 32'd0);
        else chk("tx_order", 32'(o_tx_data), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset, then a long quiet stretch with no writes.
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
    idle(1000);

    // Single byte with a delayed done pulse.
    step(1, 8'hDA, 0, 0);
    idle(20);
    step(0, 8'h00, 1, 0);
    idle(3);

    // Burst of five consecutive writes.
    for (int b = 1; b <= 5; b++) step(1, 8'(b), 0, 0);
    chk("burst_peak_count", 32'(o_count), 32'd4);
    drain();

    // Overflow: done held low, 18 writes, last one dropped.
    for (int b = 1; b <= 18; b++) step(1, 8'(b), 0, 0);
    chk("ovf_count16", 32'(o_count), 32'd16);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    drain();

    // Full FIFO with a write landing on the same edge as a pop.
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
    for (int b = 1; b <= 17; b++) step(1, 8'(8'h40 + b), 0, 0);
    idle(3);
    step(0, 8'h00, 1, 0);
    step(1, 8'hAA, 0, 0);
    chk("full_pop_count", 32'(o_count), 32'd16);
    chk("full_pop_no_ovf", 32'(o_overflow), 32'd0);
    drain();

    // Reset in the middle of a frame with bytes still queued.
    for (int b = 1; b <= 4; b++) step(1, 8'(8'h60 + b), 0, 0);
    idle(5);
    step(0, 8'h00, 0, 1);
    chk("midreset_busy", 32'(o_busy), 32'd0);
    chk("midreset_count", 32'(o_count), 32'd0);
    step(1, 8'h5A, 0, 0);
    drain();

    // Randomized traffic with spurious done pulses and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 999) == 0);
    end
    drain();

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
